// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS tone generator: FSM states,
// mid-scale helper and default parameter values.
package dds_pkg;

  localparam int DEF_NCH     = 2;
  localparam int DEF_PHASE_W = 20;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 10;
  localparam int DEF_DIV     = 5000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_READ,
    S_SEND,
    S_WAIT
  } dds_state_e;

  // Offset-binary zero level for a w-bit sample.
  function automatic int mid_scale(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// Registered-output sine ROM (offset binary, 1-cycle latency).
// Define DDS_QUARTER_WAVE_EN to store only the first quadrant and rebuild the rest.
module dds_sine_rom
  import dds_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);

  localparam int QW  = ADDR_W - 2;
  localparam int Q   = 1 << QW;
  localparam int MID = mid_scale(DATA_W);
  localparam int AMP = MID - 1;
  // pi scaled by 2^30; all table math is integer fixed point so it elaborates anywhere
  localparam longint PI_FX = 64'sd3373259426;

  // round(AMP * sin(pi/2 * j/Q)) for j in 0..Q, Taylor series in Q30.
  function automatic int quad_val(input int j);
    longint x, x2, term, sum;
    x    = (PI_FX * longint'(j)) / longint'(2 * Q);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n < 8; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      sum  = sum + term;
    end
    return int'((longint'(AMP) * sum + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic [DATA_W-1:0] w_sample;
  logic [DATA_W-1:0] r_q;

`ifdef DDS_QUARTER_WAVE_EN
  logic [DATA_W-1:0] w_qtab [Q];
  logic [1:0]        w_quad;
  logic [QW-1:0]     w_j;
  logic [QW-1:0]     w_mir;
  logic [DATA_W-1:0] w_mag;

  for (genvar j = 0; j < Q; j++) begin : g_tab
    localparam logic [DATA_W-1:0] V = DATA_W'(quad_val(j));
    assign w_qtab[j] = V;
  end

  // Odd quadrants read Q-j; j=0 there is the peak, which lies just past the table.
  always_comb begin
    w_quad   = i_addr[ADDR_W-1 -: 2];
    w_j      = i_addr[QW-1:0];
    w_mir    = w_quad[0] ? (~w_j + QW'(1)) : w_j;
    w_mag    = (w_quad[0] && (w_j == '0)) ? DATA_W'(AMP) : w_qtab[w_mir];
    w_sample = w_quad[1] ? (DATA_W'(MID) - w_mag) : (DATA_W'(MID) + w_mag);
  end
`else
  function automatic int full_val(input int k);
    int q, j, m;
    q = k >> QW;
    j = k & (Q - 1);
    m = (q % 2 == 1) ? quad_val(Q - j) : quad_val(j);
    return (q >= 2) ? (MID - m) : (MID + m);
  endfunction

  logic [DATA_W-1:0] w_tab [1 << ADDR_W];

  for (genvar k = 0; k < (1 << ADDR_W); k++) begin : g_tab
    localparam logic [DATA_W-1:0] V = DATA_W'(full_val(k));
    assign w_tab[k] = V;
  end

  assign w_sample = w_tab[i_addr];
`endif

  always_ff @(posedge clk) r_q <= w_sample;

  assign o_data = r_q;

endmodule

// File: rtl/dds_gen.sv
// Multi-channel DDS: per-tick sweep of NCH phase accumulators through a shared
// sine ROM, handing each sample to an SPI DAC. Optional DDS_QUARTER_WAVE_EN (ROM).
module dds_gen
  import dds_pkg::*;
#(
  parameter  int NCH     = DEF_NCH,
  parameter  int PHASE_W = DEF_PHASE_W,
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int DIV     = DEF_DIV,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               freq_we,
  input  logic [CH_W-1:0]    freq_ch,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               dac_busy,
  output logic               dac_start,
  output logic [DATA_W-1:0]  dac_data,
  output logic [CH_W-1:0]    dac_ch,
  output logic               tick,
  output logic               overrun
);

  localparam int DIV_W = $clog2(DIV);
  localparam int MID   = mid_scale(DATA_W);

  dds_state_e                  r_state, w_nxt;
  logic [DIV_W-1:0]            r_div;
  logic                        r_tick;
  logic                        r_ovr;
  logic [CH_W-1:0]             r_ch;
  logic [NCH-1:0][PHASE_W-1:0] r_acc;
  logic [NCH-1:0][PHASE_W-1:0] r_inc;
  logic                        r_dac_start;
  logic [DATA_W-1:0]           r_dac_data;
  logic [CH_W-1:0]             r_dac_ch;

  logic                        w_acc_en, w_send, w_ch_clr, w_ch_inc, w_last;
  logic [ADDR_W-1:0]           w_addr;
  logic [DATA_W-1:0]           w_rom;

  assign w_last = (r_ch == CH_W'(NCH - 1));
  assign w_addr = r_acc[r_ch][PHASE_W-1 -: ADDR_W];

  dds_sine_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk    (sysclk),
    .i_addr (w_addr),
    .o_data (w_rom)
  );

  always_ff @(posedge sysclk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_acc_en = 1'b0;
    w_send   = 1'b0;
    w_ch_clr = 1'b0;
    w_ch_inc = 1'b0;
    case (r_state)
      S_IDLE: if (r_tick) begin
        w_nxt    = S_ACC;
        w_ch_clr = 1'b1;
      end
      S_ACC: begin
        w_acc_en = 1'b1;
        w_nxt    = S_READ;
      end
      S_READ: w_nxt = S_SEND;
      S_SEND: if (!dac_busy) begin
        w_send = 1'b1;
        w_nxt  = S_WAIT;
      end
      S_WAIT: begin
        // one dead cycle lets the DAC raise busy before the next SEND
        if (w_last) w_nxt = S_IDLE;
        else begin
          w_nxt    = S_ACC;
          w_ch_inc = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_div       <= '0;
      r_tick      <= 1'b0;
      r_ovr       <= 1'b0;
      r_ch        <= '0;
      r_acc       <= '0;
      r_inc       <= '0;
      r_dac_start <= 1'b0;
      r_dac_data  <= DATA_W'(MID);
      r_dac_ch    <= '0;
    end else begin
      if (r_div == DIV_W'(DIV - 1)) begin
        r_div  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_div  <= r_div + 1'b1;
        r_tick <= 1'b0;
      end
      // a tick outside IDLE is dropped; the running sweep carries on
      if (r_tick && (r_state != S_IDLE)) r_ovr <= 1'b1;
      if (w_ch_clr)      r_ch <= '0;
      else if (w_ch_inc) r_ch <= r_ch + 1'b1;
      if (w_acc_en) r_acc[r_ch] <= r_acc[r_ch] + r_inc[r_ch];
      for (int c = 0; c < NCH; c++)
        if (freq_we && (freq_ch == CH_W'(c))) r_inc[c] <= freq_word;
      r_dac_start <= w_send;
      if (w_send) begin
        r_dac_data <= w_rom;
        r_dac_ch   <= r_ch;
      end
    end
  end

  assign dac_start = r_dac_start;
  assign dac_data  = r_dac_data;
  assign dac_ch    = r_dac_ch;
  assign tick      = r_tick;
  assign overrun   = r_ovr;

endmodule

// File: doc/dds_gen.md
DDS_GEN -- requirements
Module: dds_gen

Interface
REQ-001 The parameter NCH SHALL default to 2 and set the number of independent tone channels (1..8).
REQ-002 The parameter PHASE_W SHALL default to 20 and set the phase accumulator width per channel.
REQ-003 The parameter ADDR_W SHALL default to 10 and set the sine table address width (ADDR_W < PHASE_W).
REQ-004 The parameter DATA_W SHALL default to 10 and set the sample width.
REQ-005 The parameter DIV SHALL default to 5000 and set the number of sysclk cycles per sample tick (DIV >= 4*NCH+4).
REQ-006 The port sysclk SHALL be an input, 1 bit wide, and serve as the single system clock; every register is clocked on its rising edge.
REQ-007 The port reset SHALL be an input, 1 bit wide, and act as a synchronous, active-high reset.
REQ-008 The port freq_we SHALL be an input, 1 bit wide, and act as the write strobe for a frequency word.
REQ-009 The port freq_ch SHALL be an input, clog2(NCH) bits wide, and select the channel being written.
REQ-010 The port freq_word SHALL be an input, PHASE_W bits wide, and carry the phase increment.
REQ-011 The port dac_busy SHALL be an input, 1 bit wide, and be high while the downstream SPI DAC is shifting.
REQ-012 The port dac_start SHALL be an output, 1 bit wide, and be a one-cycle pulse requesting a DAC transfer.
REQ-013 The port dac_data SHALL be an output, DATA_W bits wide, and carry an offset-binary sample, valid while dac_start is high.
REQ-014 The port dac_ch SHALL be an output, clog2(NCH) bits wide, and carry the channel of dac_data.
REQ-015 The port tick SHALL be an output, 1 bit wide, and be a one-cycle sample-tick pulse.
REQ-016 The port overrun SHALL be an output, 1 bit wide, and be a sticky flag set when a tick is lost.

Function
REQ-017 The divider SHALL count 0..DIV-1 and assert tick for one cycle when the count wraps to 0.
REQ-018 The FSM SHALL have the states IDLE, ACC, READ, SEND and WAIT; the states SHALL cycle IDLE->ACC->READ->SEND->WAIT.
REQ-019 The IDLE state SHALL move to ACC on tick, with the channel index set to 0.
REQ-020 In the ACC state, the accumulator of the current channel SHALL be updated as acc = acc + inc modulo 2^PHASE_W, wrapping silently.
REQ-021 In the READ state, the ROM address SHALL be acc[PHASE_W-1 -: ADDR_W] and the ROM output SHALL be registered with 1-cycle latency.
REQ-022 In the SEND state, the FSM SHALL wait while dac_busy=1 and, once dac_busy=0, pulse dac_start with dac_data and dac_ch stable.
REQ-023 The WAIT state SHALL hold for one cycle so that dac_busy can rise, then go to ACC for the next channel, or to IDLE after channel NCH-1.
REQ-024 If a tick arrives while the FSM is not in IDLE, the tick SHALL be dropped, overrun SHALL be set, and the sweep in progress SHALL continue.
REQ-025 A freq_we write SHALL take effect at the next ACC state of the addressed channel; a write in the same cycle as that channel's ACC SHALL use the old increment.
REQ-026 A write with freq_ch >= NCH SHALL be ignored.
REQ-027 The table SHALL hold round((2^(DATA_W-1)-1)*sin(2*pi*k/2^ADDR_W)) + 2^(DATA_W-1); phase 0 gives 2^(DATA_W-1).
REQ-028 An increment of 0 SHALL freeze that channel at its current sample, which is still sent on every tick.

Reset
REQ-029 On reset, the divider, all accumulators and all increments SHALL clear to 0, the FSM SHALL enter IDLE, and dac_start, tick and overrun SHALL clear to 0.
REQ-030 On reset, dac_data SHALL be 2^(DATA_W-1) and dac_ch SHALL be 0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep with no further dac_start pulse.
REQ-032 The overrun flag SHALL clear only on reset.

Configuration
REQ-033 With DDS_QUARTER_WAVE_EN defined, the ROM SHALL store 2^(ADDR_W-2) entries of the first quadrant.
REQ-034 With DDS_QUARTER_WAVE_EN defined, the quadrant bits SHALL mirror the address and invert the sample about mid-scale; the result SHALL be within 1 LSB of the full table and the ROM latency SHALL be unchanged.
REQ-035 Without DDS_QUARTER_WAVE_EN, the ROM SHALL hold the full 2^ADDR_W-entry table.

Structure
REQ-036 The package dds_pkg SHALL hold the FSM state enum, a mid-scale constant function, and the default parameter constants.
REQ-037 The sine table SHALL be one sub-module, dds_sine_rom, containing the registered-output ROM with the quarter-wave logic inside.

Verification
REQ-038 Reset then release, no writes: each tick gives NCH dac_start pulses, dac_data=512 and dac_ch=0,1.
REQ-039 freq_word=2^(PHASE_W-2) on ch0: ch0 samples are 512, 1023, 512, 1 and repeat with period 4 ticks.
REQ-040 With the bench holding dac_busy=1 for 6*DIV cycles: overrun=1, no samples lost within the sweep, and sweeps resume afterward.
REQ-041 Accumulator near 2^PHASE_W-1 plus an increment: the accumulator wraps to the low residue and the sine continues without a discontinuity.
REQ-042 Assert reset during SEND with dac_busy=1: no dac_start pulse and all outputs at their reset values next cycle.
REQ-043 Compile with and without DDS_QUARTER_WAVE_EN and sweep all 2^ADDR_W addresses: the two builds' outputs differ by at most 1 LSB.
